// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch resolution, flush/redirect and buffered BTB update queue
// Optional statistics counters enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int UPD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pred_next,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        ex_bcond,
    input  logic [31:0] ex_pc_plus_imm,
    input  logic [31:0] ex_alu_result,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0] stat_ctrl_count,
    output logic [31:0] stat_mispredict_count,
    output logic [31:0] stat_upd_drop_count
`endif
);

    localparam int PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(UPD_DEPTH);

    // Metadata pipeline slots
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pred_q, id_pred_d;
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_pred_q, ex_pred_d;

    // Update FIFO
    logic [31:0] fifo_pc_q     [UPD_DEPTH];
    logic [31:0] fifo_pc_d     [UPD_DEPTH];
    logic [31:0] fifo_target_q [UPD_DEPTH];
    logic [31:0] fifo_target_d [UPD_DEPTH];
    logic        fifo_taken_q  [UPD_DEPTH];
    logic        fifo_taken_d  [UPD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] actual;
    logic        is_ctrl;
    logic        taken;
    logic        mispredict;
    logic        push_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic        do_push;
    logic        do_pop;
    logic        drop;

    always_comb begin
        pc_plus4 = ex_pc_q + 32'd4;
        actual   = pc_plus4;
        if (ex_is_jal) begin
            actual = ex_pc_plus_imm;
        end else if (ex_is_jalr) begin
            actual = {ex_alu_result[31:1], 1'b0};
        end else if (ex_is_branch) begin
            actual = ex_bcond ? ex_pc_plus_imm : pc_plus4;
        end

        is_ctrl    = ex_is_jal | ex_is_jalr | ex_is_branch;
        taken      = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_bcond);
        mispredict = ex_valid_q & (ex_pred_q != actual);
        flush      = mispredict & ~stall;
        redirect_pc = flush ? actual : 32'd0;

        // A non-control mispredict is a BTB alias; actual is pc+4 and taken is 0 then.
        push_req   = ~stall & ex_valid_q & (is_ctrl | mispredict);
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        do_pop     = ~fifo_empty & upd_ready;
        do_push    = push_req & (~fifo_full | do_pop);
        drop       = push_req & ~do_push;

        upd_valid  = ~fifo_empty;
        upd_pc     = fifo_pc_q[rd_ptr_q];
        upd_target = fifo_target_q[rd_ptr_q];
        upd_taken  = fifo_taken_q[rd_ptr_q];
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pred_d  = id_pred_q;
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_pred_d  = ex_pred_q;
        if (!stall) begin
            id_valid_d = if_valid & ~flush;
            id_pc_d    = if_pc;
            id_pred_d  = if_pred_next;
            ex_valid_d = id_valid_q & ~flush;
            ex_pc_d    = id_pc_q;
            ex_pred_d  = id_pred_q;
        end
    end

    always_comb begin
        fifo_pc_d     = fifo_pc_q;
        fifo_target_d = fifo_target_q;
        fifo_taken_d  = fifo_taken_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (do_push) begin
            fifo_pc_d[wr_ptr_q]     = ex_pc_q;
            fifo_target_d[wr_ptr_q] = actual;
            fifo_taken_d[wr_ptr_q]  = taken;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_pred_q  <= '0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_pred_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            // Storage is cleared so the head fields read zero out of reset.
            for (int i = 0; i < UPD_DEPTH; i++) begin
                fifo_pc_q[i]     <= '0;
                fifo_target_q[i] <= '0;
                fifo_taken_q[i]  <= 1'b0;
            end
        end else begin
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pred_q  <= id_pred_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_pred_q  <= ex_pred_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_target_q <= fifo_target_d;
            fifo_taken_q  <= fifo_taken_d;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_ctrl_q, stat_ctrl_d;
    logic [31:0] stat_misp_q, stat_misp_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_ctrl_d = stat_ctrl_q;
        stat_misp_d = stat_misp_q;
        stat_drop_d = stat_drop_q;
        if (~stall & ex_valid_q & is_ctrl) begin
            stat_ctrl_d = stat_ctrl_q + 32'd1;
        end
        if (flush) begin
            stat_misp_d = stat_misp_q + 32'd1;
        end
        if (drop) begin
            stat_drop_d = stat_drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ctrl_q <= '0;
            stat_misp_q <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_ctrl_q <= stat_ctrl_d;
            stat_misp_q <= stat_misp_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_ctrl_count       = stat_ctrl_q;
    assign stat_mispredict_count = stat_misp_q;
    assign stat_upd_drop_count   = stat_drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pred_next;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_bcond;
    logic [31:0] ex_pc_plus_imm;
    logic [31:0] ex_alu_result;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;

    int n_pass  = 0;
    int n_total = 0;

    branch_resolver #(.UPD_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred_next   (if_pred_next),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_bcond       (ex_bcond),
        .ex_pc_plus_imm (ex_pc_plus_imm),
        .ex_alu_result  (ex_alu_result),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_is_branch   = 1'b0;
        ex_is_jal      = 1'b0;
        ex_is_jalr     = 1'b0;
        ex_bcond       = 1'b0;
        ex_pc_plus_imm = 32'h0;
        ex_alu_result  = 32'h0;
    endtask

    // Fetch one instruction followed by a bubble; on return it sits in EX.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] pred);
        if_valid = 1'b1;
        if_pc = pc;
        if_pred_next = pred;
        tick();
        if_valid = 1'b0;
        tick();
    endtask

    task automatic check_upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic tk);
        check({tag, "_valid"}, 32'(upd_valid), 32'd1);
        check({tag, "_pc"}, upd_pc, pc);
        check({tag, "_target"}, upd_target, tgt);
        check({tag, "_taken"}, 32'(upd_taken), 32'(tk));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = 32'h0; if_pred_next = 32'h0;
        upd_ready = 1'b1;
        clear_ex();
        tick(); tick();
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_upd_pc", upd_pc, 32'h0);
        check("rst_upd_target", upd_target, 32'h0);
        check("rst_upd_taken", 32'(upd_taken), 32'd0);
        reset = 1'b0;
        tick();

        // Correctly predicted not-taken branch
        fetch(32'h100, 32'h104);
        ex_is_branch = 1'b1; ex_bcond = 1'b0; ex_pc_plus_imm = 32'h180;
        #1 check("nt_flush", 32'(flush), 32'd0);
        check("nt_redirect", redirect_pc, 32'h0);
        tick(); clear_ex();
        check_upd("nt_upd", 32'h100, 32'h104, 1'b0);
        tick();
        check("nt_popped", 32'(upd_valid), 32'd0);

        // Taken branch predicted not-taken; younger fetch must be killed
        fetch(32'h200, 32'h204);
        ex_is_branch = 1'b1; ex_bcond = 1'b1; ex_pc_plus_imm = 32'h240;
        if_valid = 1'b1; if_pc = 32'h600; if_pred_next = 32'h0;
        #1 check("tk_flush", 32'(flush), 32'd1);
        check("tk_redirect", redirect_pc, 32'h240);
        tick(); clear_ex(); if_valid = 1'b0;
        check_upd("tk_upd", 32'h200, 32'h240, 1'b1);
        check("tk_ex_invalid", 32'(flush), 32'd0);
        tick();
        check("tk_id_killed", 32'(flush), 32'd0);
        check("tk_no_push", 32'(upd_valid), 32'd0);

        // JALR with LSB cleared matches prediction
        fetch(32'h300, 32'h400);
        ex_is_jalr = 1'b1; ex_alu_result = 32'h401;
        #1 check("jalr_flush", 32'(flush), 32'd0);
        tick(); clear_ex();
        check_upd("jalr_upd", 32'h300, 32'h400, 1'b1);
        tick();

        // BTB alias on a non-control instruction
        fetch(32'h500, 32'h80);
        #1 check("alias_flush", 32'(flush), 32'd1);
        check("alias_redirect", redirect_pc, 32'h504);
        tick();
        check_upd("alias_upd", 32'h500, 32'h504, 1'b0);
        tick();

        // JAL wins over a simultaneously asserted branch bit
        fetch(32'h700, 32'h704);
        ex_is_jal = 1'b1; ex_is_branch = 1'b1; ex_bcond = 1'b0; ex_pc_plus_imm = 32'h780;
        #1 check("jal_flush", 32'(flush), 32'd1);
        check("jal_redirect", redirect_pc, 32'h780);
        tick(); clear_ex();
        check_upd("jal_upd", 32'h700, 32'h780, 1'b1);
        tick();

        // Correctly predicted non-control: no push
        fetch(32'h800, 32'h804);
        #1 check("seq_flush", 32'(flush), 32'd0);
        tick();
        check("seq_no_push", 32'(upd_valid), 32'd0);

        // FIFO full: third update dropped
        upd_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hA00; if_pred_next = 32'hA04; tick();
        if_pc = 32'hA04; if_pred_next = 32'hA08; tick();
        if_pc = 32'hA08; if_pred_next = 32'hA0C; ex_is_branch = 1'b1; tick();
        if_valid = 1'b0; tick();
        tick();
        clear_ex();
        check_upd("full_head0", 32'hA00, 32'hA04, 1'b0);
        upd_ready = 1'b1;
        #1 check("full_head0_hold", upd_pc, 32'hA00);
        tick();
        check_upd("full_head1", 32'hA04, 32'hA08, 1'b0);
        tick();
        check("full_drained", 32'(upd_valid), 32'd0);

        // Stall during a mispredicting EX
        fetch(32'hB00, 32'h0);
        stall = 1'b1;
        if_valid = 1'b1; if_pc = 32'hC00; if_pred_next = 32'hC04;
        #1 check("stall_flush", 32'(flush), 32'd0);
        check("stall_redirect", redirect_pc, 32'h0);
        tick();
        check("stall_held_flush", 32'(flush), 32'd0);
        check("stall_no_push", 32'(upd_valid), 32'd0);
        stall = 1'b0; if_valid = 1'b0;
        #1 check("unstall_flush", 32'(flush), 32'd1);
        check("unstall_redirect", redirect_pc, 32'hB04);
        tick();
        check_upd("unstall_upd", 32'hB00, 32'hB04, 1'b0);
        tick();

        // Reset with two pending updates
        upd_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hD00; if_pred_next = 32'hD04; tick();
        if_pc = 32'hD04; if_pred_next = 32'hD08; tick();
        if_valid = 1'b0; ex_is_branch = 1'b1; tick();
        tick();
        clear_ex();
        check("pre_rst_valid", 32'(upd_valid), 32'd1);
        check("pre_rst_pc", upd_pc, 32'hD00);
        reset = 1'b1;
        tick();
        check("post_rst_valid", 32'(upd_valid), 32'd0);
        check("post_rst_pc", upd_pc, 32'h0);
        reset = 1'b0;
        upd_ready = 1'b1;
        tick();
        check("post_rst_stay_empty", 32'(upd_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
